// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the fetch/decode instruction queue
package rv32i_types;

  localparam int IQ_XLEN  = 32;
  localparam int IQ_DEPTH = 8;
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic [IQ_XLEN-1:0] pc;
    logic [IQ_XLEN-1:0] next_pc;
    logic [IQ_XLEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/iqueue_multiport_storage.sv
// rtl/iqueue_multiport_storage.sv - entry array with multi-lane writes and async reads
module iq_storage
  import rv32i_types::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_ENQ = 2,
  parameter int NUM_DEQ = 2,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic      [NUM_ENQ-1:0]           we,
  input  logic      [NUM_ENQ-1:0][PTR_W-1:0] waddr,
  input  iq_entry_t [NUM_ENQ-1:0]           wdata,
  input  logic      [NUM_DEQ-1:0][PTR_W-1:0] raddr,
  output iq_entry_t [NUM_DEQ-1:0]           rdata
);

  iq_entry_t mem [DEPTH];

  // Write addresses are consecutive slots, so lanes never collide.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ENQ; k++) begin
      if (we[k]) mem[waddr[k]] <= wdata[k];
    end
  end

  for (genvar k = 0; k < NUM_DEQ; k++) begin : g_rd
    assign rdata[k] = mem[raddr[k]];
  end

endmodule

// File: rtl/iqueue_multiport.sv
// rtl/iqueue_multiport.sv - circular multi-port FWFT instruction queue, fetch to decode
module iqueue_multiport
  import rv32i_types::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_ENQ = 2,
  parameter int NUM_DEQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_ENQ-1:0]           enq_valid,
  input  logic [NUM_ENQ*XLEN-1:0]      enq_pc,
  input  logic [NUM_ENQ*XLEN-1:0]      enq_next_pc,
  input  logic [NUM_ENQ*XLEN-1:0]      enq_instr,
  output logic                         enq_ready,
  output logic [NUM_DEQ-1:0]           deq_valid,
  output logic [NUM_DEQ*XLEN-1:0]      deq_pc,
  output logic [NUM_DEQ*XLEN-1:0]      deq_next_pc,
  output logic [NUM_DEQ*XLEN-1:0]      deq_instr,
  input  logic [$clog2(NUM_DEQ+1)-1:0] deq_take,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  if (XLEN != IQ_XLEN) begin : g_xlen_check
    $error("iqueue_multiport: XLEN must match rv32i_types::IQ_XLEN");
  end

  logic [PTR_W-1:0] head, tail;
  logic [CW-1:0]    n_enq, n_acc, take;
  logic             run;

  logic      [NUM_ENQ-1:0]            we;
  logic      [NUM_ENQ-1:0][PTR_W-1:0] waddr;
  iq_entry_t [NUM_ENQ-1:0]            wdata;
  logic      [NUM_DEQ-1:0][PTR_W-1:0] raddr;
  iq_entry_t [NUM_DEQ-1:0]            rdata;

  // Ready looks only at registered occupancy; same-cycle frees do not count.
  assign enq_ready = (count <= CW'(DEPTH - NUM_ENQ));
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));

  always_comb begin
    n_enq = '0;
    run   = 1'b1;
    for (int k = 0; k < NUM_ENQ; k++) begin
      if (run && enq_valid[k]) n_enq = n_enq + CW'(1);
      else                     run   = 1'b0;
    end
    n_acc = enq_ready ? n_enq : '0;
  end

  always_comb begin
    take = CW'(deq_take);
    if (take > count)         take = count;
    if (take > CW'(NUM_DEQ))  take = CW'(NUM_DEQ);
  end

  for (genvar k = 0; k < NUM_ENQ; k++) begin : g_wr
    assign we[k]    = !rst && !flush && (CW'(k) < n_acc);
    assign waddr[k] = tail + PTR_W'(k);
    assign wdata[k] = '{pc:      enq_pc[k*XLEN +: XLEN],
                        next_pc: enq_next_pc[k*XLEN +: XLEN],
                        instr:   enq_instr[k*XLEN +: XLEN]};
  end

  for (genvar k = 0; k < NUM_DEQ; k++) begin : g_rd
    assign raddr[k]                    = head + PTR_W'(k);
    assign deq_valid[k]                = (count > CW'(k));
    assign deq_pc[k*XLEN +: XLEN]      = deq_valid[k] ? rdata[k].pc      : '0;
    assign deq_next_pc[k*XLEN +: XLEN] = deq_valid[k] ? rdata[k].next_pc : '0;
    assign deq_instr[k*XLEN +: XLEN]   = deq_valid[k] ? rdata[k].instr   : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(take);
      tail  <= tail + PTR_W'(n_acc);
      count <= count + n_acc - take;
    end
  end

  iq_storage #(
    .DEPTH   (DEPTH),
    .NUM_ENQ (NUM_ENQ),
    .NUM_DEQ (NUM_DEQ),
    .PTR_W   (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_iqueue_multiport.sv
// tb/tb_iqueue_multiport.sv - directed and random checks against a queue-based model
module tb_iqueue_multiport;

  localparam int DEPTH = 8;
  localparam int NE    = 2;
  localparam int ND    = 2;
  localparam int XL    = 32;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [NE-1:0]   enq_valid;
  logic [NE*XL-1:0] enq_pc, enq_next_pc, enq_instr;
  logic            enq_ready;
  logic [ND-1:0]   deq_valid;
  logic [ND*XL-1:0] deq_pc, deq_next_pc, deq_instr;
  logic [1:0]      deq_take;
  logic [3:0]      count;
  logic            empty, full;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ins;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  iqueue_multiport #(.DEPTH(DEPTH), .NUM_ENQ(NE), .NUM_DEQ(ND), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_next_pc(enq_next_pc), .enq_instr(enq_instr),
    .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_next_pc(deq_next_pc),
    .deq_instr(deq_instr), .deq_take(deq_take), .count(count), .empty(empty), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_enq(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    enq_valid   = v;
    enq_pc      = {pc1, pc0};
    enq_next_pc = {pc1 + 32'd4, pc0 + 32'd4};
    enq_instr   = {pc1 ^ 32'hA5A5_0013, pc0 ^ 32'hA5A5_0013};
  endtask

  task automatic check_all();
    int sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("enq_ready", 32'(enq_ready), 32'(DEPTH - sz >= NE));
    chk("count_bound", 32'(count <= DEPTH), 32'd1);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("deq_valid%0d", k), 32'(deq_valid[k]), 32'(sz > k));
      chk($sformatf("deq_pc%0d", k), deq_pc[k*XL +: XL], (sz > k) ? q[k].pc : 32'd0);
      chk($sformatf("deq_npc%0d", k), deq_next_pc[k*XL +: XL], (sz > k) ? q[k].npc : 32'd0);
      chk($sformatf("deq_ins%0d", k), deq_instr[k*XL +: XL], (sz > k) ? q[k].ins : 32'd0);
    end
  endtask

  // One clock: model the queue from the inputs presented, advance, then compare.
  task automatic step();
    int   sz = q.size();
    bit   rdy = (DEPTH - sz) >= NE;
    int   nen = 0;
    int   tk;
    ent_t e;
    for (int k = 0; k < NE; k++) begin
      if (enq_valid[k] && nen == k) nen++;
    end
    tk = int'(deq_take);
    if (tk > sz) tk = sz;
    if (tk > ND) tk = ND;
    @(posedge clk);
    #1;
    if (rst || flush) begin
      q.delete();
    end else begin
      repeat (tk) void'(q.pop_front());
      if (rdy) begin
        for (int k = 0; k < nen; k++) begin
          e.pc  = enq_pc[k*XL +: XL];
          e.npc = enq_next_pc[k*XL +: XL];
          e.ins = enq_instr[k*XL +: XL];
          q.push_back(e);
        end
      end
    end
    check_all();
  endtask

  task automatic idle();
    set_enq(2'b00, 32'd0, 32'd0);
    deq_take = 2'd0;
    flush    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    chk("reset_empty", 32'(empty), 32'd1);

    // Take while empty
    deq_take = 2'd2;
    step();
    deq_take = 2'd0;

    // Dual enqueue then dequeue
    set_enq(2'b11, 32'h100, 32'h104); step();
    set_enq(2'b11, 32'h108, 32'h10C); step();
    idle(); step();
    chk("dual_lane0", deq_pc[31:0], 32'h100);
    chk("dual_lane1", deq_pc[63:32], 32'h104);
    deq_take = 2'd2; step();
    chk("dual_after_take", deq_pc[31:0], 32'h108);
    chk("dual_count", 32'(count), 32'd2);

    // Fill to full, then backpressure with same-cycle dequeue
    idle(); flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_enq(2'b11, 32'h1000 + 32'(i*8), 32'h1004 + 32'(i*8));
      step();
    end
    chk("full_flag", 32'(full), 32'd1);
    set_enq(2'b01, 32'h200, 32'h0);
    deq_take = 2'd1;
    step();
    chk("bp_count", 32'(count), 32'd7);
    chk("bp_ready_low", 32'(enq_ready), 32'd0);
    step();
    chk("bp_ready_high", 32'(enq_ready), 32'd1);
    deq_take = 2'd0; step();

    // Wrap-around: move pointers to 6, then stream pairs across index 7 -> 0
    idle(); flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(2'b11, 32'h2000 + 32'(i*8), 32'h2004 + 32'(i*8)); step();
    end
    idle(); deq_take = 2'd2;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      set_enq(2'b11, 32'h300 + 32'(i*8), 32'h304 + 32'(i*8));
      deq_take = 2'd0;
      step();
    end
    chk("wrap_head", deq_pc[31:0], 32'h300);
    idle(); deq_take = 2'd2;
    step();
    chk("wrap_lane0", deq_pc[31:0], 32'h308);
    chk("wrap_lane1", deq_pc[63:32], 32'h30C);
    step(); step();

    // Flush mid-operation with enq and deq active
    idle();
    set_enq(2'b11, 32'h600, 32'h604); step();
    set_enq(2'b11, 32'h608, 32'h60C); step();
    set_enq(2'b01, 32'h610, 32'h0);   step();
    chk("pre_flush_count", 32'(count), 32'd5);
    set_enq(2'b11, 32'h700, 32'h704); deq_take = 2'd2; flush = 1'b1;
    step();
    chk("flush_empty", 32'(empty), 32'd1);
    idle(); set_enq(2'b01, 32'h400, 32'h0); step();
    chk("post_flush_lane0", deq_pc[31:0], 32'h400);

    // Single-lane, clamping, non-contiguous lanes
    idle(); flush = 1'b1; step(); flush = 1'b0;
    set_enq(2'b01, 32'h500, 32'h0); step();
    chk("single_valid", 32'(deq_valid), 32'b01);
    idle(); deq_take = 2'd2; step();
    chk("clamp_count", 32'(count), 32'd0);
    idle(); set_enq(2'b10, 32'h0, 32'h510); step();
    chk("noncontig_count", 32'(count), 32'd0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 2);
      logic [31:0] p = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) * 4);
      set_enq(r == 0 ? 2'b00 : (r == 1 ? 2'b01 : 2'b11), p, p + 32'd4);
      deq_take = 2'($urandom_range(0, 2));
      flush    = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
